// File: rtl/serial_cmd_engine.sv
// Byte-serial framed command engine between a UART byte pair and a word memory port.
// Acts one cycle after each assembled word; tx paced by tx_ready, bytes arriving while transmitting are dropped (overrun).
module serial_cmd_engine #(
    parameter int          WORD_W         = 32,
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] INFO_ID        = 32'h4D495053
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_ready,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              overrun
);
    localparam int                BYTES    = WORD_W / 8;
    localparam int                BW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0]     LAST_B   = BW'(BYTES - 1);
    localparam logic [WORD_W-1:0] INFO_W0  = WORD_W'(INFO_ID);
    localparam logic [WORD_W-1:0] INFO_W1  = WORD_W'(WORD_W);
    localparam logic [WORD_W-1:0] INFO_W2  = WORD_W'(ADDR_W);
    localparam logic [31:0]       TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        RD_LEN, RD_CMD, RD_ARG, UP_DATA, DL_READ, DL_WAIT, SEND, DRAIN, STATUS
    } state_t;

    state_t            r_state, w_nstate;
    logic [WORD_W-1:0] r_shift, r_len, r_cnt, r_txw, r_mem_wdata, w_ld_val;
    logic [BW-1:0]     r_bcnt, r_bidx;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_tcnt;
    logic [1:0]        r_cmd, r_info, r_dcode, w_code;
    logic [7:0]        r_tx_byte;
    logic              r_wdone, r_argi, r_tx_start, r_mem_wr, r_mem_rd, r_overrun;
    logic              w_rx_states, w_rx_ok, w_tcount, w_tmo, w_fire, w_ld_tx;
    logic              w_to_status, w_to_drain;

    assign w_rx_states = (r_state == RD_LEN) || (r_state == RD_CMD) || (r_state == RD_ARG) ||
                         (r_state == UP_DATA) || (r_state == DRAIN);
    assign w_rx_ok     = rx_valid && w_rx_states;
    assign w_tcount    = (w_rx_states && (r_state != RD_LEN)) || ((r_state == RD_LEN) && (r_bcnt != '0));
    assign w_tmo       = w_tcount && !rx_valid && (r_tcnt == TMO_LAST);
    assign w_fire      = ((r_state == SEND) || (r_state == STATUS)) && tx_ready && !r_tx_start;

    always_comb begin
        w_nstate    = r_state;
        w_ld_tx     = 1'b0;
        w_ld_val    = '0;
        w_code      = 2'd0;
        w_to_status = 1'b0;
        w_to_drain  = 1'b0;
        case (r_state)
            RD_LEN: if (r_wdone) w_nstate = RD_CMD;
            RD_CMD: if (r_wdone) begin
                w_code = 2'd3;
                if (r_shift == WORD_W'(0)) begin
                    if (r_len == '0) begin w_code = 2'd0; w_to_status = 1'b1; end
                    else w_to_drain = 1'b1;
                end else if (r_shift == WORD_W'(1)) begin
                    if (r_len == '0) begin w_nstate = SEND; w_ld_tx = 1'b1; w_ld_val = INFO_W0; end
                    else w_to_drain = 1'b1;
                end else if (r_shift == WORD_W'(2)) begin
                    if (r_len != '0) w_nstate = RD_ARG;
                    else w_to_drain = 1'b1;
                end else if (r_shift == WORD_W'(3)) begin
                    if (r_len == WORD_W'(2)) w_nstate = RD_ARG;
                    else w_to_drain = 1'b1;
                end else begin
                    w_code     = 2'd1;
                    w_to_drain = 1'b1;
                end
                if (w_to_drain) begin
                    if (r_len == '0) w_to_status = 1'b1;
                    else w_nstate = DRAIN;
                end
            end
            RD_ARG: if (r_wdone) begin
                if (r_cmd == 2'd2) begin
                    if (r_cnt == WORD_W'(1)) w_to_status = 1'b1;
                    else w_nstate = UP_DATA;
                end else if (r_argi) begin
                    if (r_shift == '0) w_to_status = 1'b1;
                    else w_nstate = DL_READ;
                end
            end
            UP_DATA: if (r_wdone && (r_cnt == WORD_W'(1))) w_to_status = 1'b1;
            DRAIN:   if (r_wdone && (r_cnt == WORD_W'(1))) begin
                w_code      = r_dcode;
                w_to_status = 1'b1;
            end
            DL_READ: w_nstate = DL_WAIT;
            DL_WAIT: if (mem_rvalid) begin
                w_nstate = SEND;
                w_ld_tx  = 1'b1;
                w_ld_val = mem_rdata;
            end
            SEND: if (w_fire && (r_bidx == LAST_B)) begin
                if (r_cmd == 2'd1) begin
                    if (r_info == 2'd0) begin w_ld_tx = 1'b1; w_ld_val = INFO_W1; end
                    else if (r_info == 2'd1) begin w_ld_tx = 1'b1; w_ld_val = INFO_W2; end
                    else w_to_status = 1'b1;
                end else if (r_cnt != '0) w_nstate = DL_READ;
                else w_to_status = 1'b1;
            end
            STATUS: if (w_fire && (r_bidx == LAST_B)) w_nstate = RD_LEN;
            default: w_nstate = RD_LEN;
        endcase
        // A completed word in hand wins over a timeout landing in the same cycle.
        if (w_tmo && !r_wdone) begin
            w_code      = 2'd2;
            w_to_status = 1'b1;
        end
        if (w_to_status) begin
            w_nstate = STATUS;
            w_ld_tx  = 1'b1;
            w_ld_val = WORD_W'(w_code);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RD_LEN;
        else      r_state <= w_nstate;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0; r_len <= '0; r_cnt <= '0; r_txw <= '0; r_mem_wdata <= '0;
            r_bcnt <= '0; r_bidx <= '0; r_addr <= '0; r_tcnt <= '0;
            r_cmd <= '0; r_info <= '0; r_dcode <= '0; r_tx_byte <= '0;
            r_wdone <= 1'b0; r_argi <= 1'b0; r_tx_start <= 1'b0;
            r_mem_wr <= 1'b0; r_mem_rd <= 1'b0; r_overrun <= 1'b0;
        end else begin
            r_tx_start <= w_fire;
            if (w_fire) r_tx_byte <= r_txw[WORD_W-1 -: 8];
            if (w_ld_tx) begin
                r_txw  <= w_ld_val;
                r_bidx <= '0;
            end else if (w_fire) begin
                r_txw  <= r_txw << 8;
                r_bidx <= r_bidx + 1'b1;
            end
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_wdone  <= 1'b0;
            if (w_rx_ok) begin
                r_shift <= {r_shift[WORD_W-9:0], rx_byte};
                if (r_bcnt == LAST_B) begin
                    r_bcnt  <= '0;
                    r_wdone <= 1'b1;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end else if (w_tmo) begin
                r_bcnt <= '0;
            end
            if (rx_valid && !w_rx_states) r_overrun <= 1'b1;
            if (rx_valid || !w_tcount || w_tmo) r_tcnt <= '0;
            else                                r_tcnt <= r_tcnt + 32'd1;
            if (r_mem_wr) r_addr <= r_addr + 1'b1;
            case (r_state)
                RD_LEN: if (r_wdone) r_len <= r_shift;
                RD_CMD: if (r_wdone) begin
                    r_cmd   <= r_shift[1:0];
                    r_cnt   <= r_len;
                    r_argi  <= 1'b0;
                    r_info  <= 2'd0;
                    r_dcode <= w_code;
                end
                RD_ARG: if (r_wdone) begin
                    if (!r_argi) begin
                        r_addr <= r_shift[ADDR_W-1:0];
                        r_cnt  <= r_cnt - 1'b1;
                        r_argi <= 1'b1;
                    end else begin
                        r_cnt <= r_shift;
                    end
                end
                UP_DATA: if (r_wdone) begin
                    r_mem_wr    <= 1'b1;
                    r_mem_wdata <= r_shift;
                    r_cnt       <= r_cnt - 1'b1;
                end
                DRAIN:   if (r_wdone) r_cnt <= r_cnt - 1'b1;
                DL_READ: r_mem_rd <= 1'b1;
                DL_WAIT: if (mem_rvalid) begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt - 1'b1;
                end
                SEND: if (w_fire && (r_bidx == LAST_B)) r_info <= r_info + 1'b1;
                default: ;
            endcase
        end
    end

    assign tx_byte   = r_tx_byte;
    assign tx_start  = r_tx_start;
    assign mem_wr    = r_mem_wr;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != RD_LEN) || (r_bcnt != '0);
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed bench for serial_cmd_engine: frame-level model predicts tx bytes, writes and reads.
module tb_serial_cmd_engine;
    localparam int TMO = 40;

    logic        clk = 1'b0, rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00, tx_byte;
    logic        rx_valid = 1'b0, tx_start, tx_ready, mem_wr, mem_rd, mem_rvalid, busy, overrun;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    serial_cmd_engine #(.WORD_W(32), .ADDR_W(16), .TIMEOUT_CYCLES(TMO), .INFO_ID(32'h4D495053)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_ready(tx_ready),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy), .overrun(overrun)
    );

    int          n_cmp = 0, n_fail = 0, cyc = 0, t_rx = 0, t_tx1 = -1;
    logic [7:0]  exp_tx[$], act_tx[$];
    logic [47:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [31:0] pl[$];
    logic [31:0] mem_m [logic [15:0]];
    logic [15:0] last_wr_addr = 16'h1234, ra;
    logic        prev_start = 1'b0, prev_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: strobe seen (1), expected none (0)", nm);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    endtask

    // Frame-level model: status rules and side effects straight from the command table.
    task automatic model_frame(input logic [31:0] len, input logic [31:0] cmd);
        logic [31:0] st;
        logic [15:0] a;
        st = 32'd0;
        case (cmd)
            32'd0: if (len != 0) st = 32'd3;
            32'd1: if (len == 0) begin
                push_word(32'h4D495053); push_word(32'd32); push_word(32'd16);
            end else st = 32'd3;
            32'd2: if (len >= 1) begin
                for (int i = 1; i < int'(len); i++) begin
                    a = 16'(pl[0] + 32'(i) - 32'd1);
                    exp_wr.push_back({a, pl[i]});
                end
            end else st = 32'd3;
            32'd3: if (len == 2) begin
                for (int i = 0; i < int'(pl[1]); i++) begin
                    a = 16'(pl[0] + 32'(i));
                    exp_rd.push_back(a);
                    push_word(mem_m.exists(a) ? mem_m[a] : 32'h0);
                end
            end else st = 32'd3;
            default: st = 32'd1;
        endcase
        push_word(st);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; rx_valid = 1'b1; t_rx = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic run_frame(input logic [31:0] len, input logic [31:0] cmd);
        act_tx.delete();
        model_frame(len, cmd);
        send_word(len);
        send_word(cmd);
        foreach (pl[i]) send_word(pl[i]);
    endtask

    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 && !busy) break;
        end
        check(nm, 64'(k < 3000), 64'd1);
    endtask

    // Compare process: every tx byte and memory strobe against the model queues.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_start) begin
                act_tx.push_back(tx_byte);
                if (t_tx1 < 0) t_tx1 = cyc;
                check("tx_start_after_ready", 64'(prev_ready), 64'd1);
                check("tx_start_not_back_to_back", 64'(prev_start), 64'd0);
                if (exp_tx.size() == 0) unexpected("tx_start");
                else check("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
            end
            if (mem_wr) begin
                last_wr_addr = mem_addr;
                if (exp_wr.size() == 0) unexpected("mem_wr");
                else check("mem_wr_addr_data", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_wr.pop_front()});
            end
            if (mem_rd) begin
                if (exp_rd.size() == 0) unexpected("mem_rd");
                else check("mem_rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
            end
            prev_start = tx_start;
            prev_ready = tx_ready;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && tx_start) begin
                @(posedge clk); #1 tx_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        end
    end

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && mem_rd) begin
                ra = mem_addr;
                repeat (3) @(posedge clk);
                #1;
                mem_rdata  = mem_m.exists(ra) ? mem_m[ra] : 32'h0;
                mem_rvalid = 1'b1;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        mem_m[16'h0010] = 32'hAABBCCDD;
        mem_m[16'h0011] = 32'h01020304;
        repeat (3) @(negedge clk);
        check("reset_outputs_held", {14'h0, tx_start, tx_byte, mem_wr, mem_rd, mem_addr, mem_wdata, busy, overrun}, 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs_released", {14'h0, tx_start, tx_byte, mem_wr, mem_rd, mem_addr, mem_wdata, busy, overrun}, 64'h0);

        pl.delete();
        run_frame(32'd0, 32'd0);
        wait_done("nop_done");
        check("nop_byte_count", 64'(act_tx.size()), 64'd4);

        run_frame(32'd0, 32'd1);
        wait_done("info_done");
        check("info_byte_count", 64'(act_tx.size()), 64'd16);
        check("info_first_byte", 64'(act_tx[0]), 64'h4D);
        check("info_word_w", 64'(act_tx[7]), 64'h20);
        check("info_addr_w", 64'(act_tx[11]), 64'h10);

        pl = '{32'h0000FFFE, 32'h11111111, 32'h22222222, 32'h33333333};
        run_frame(32'd4, 32'd2);
        wait_done("upload_done");
        check("upload_wrap_addr", 64'(last_wr_addr), 64'h0000);
        check("upload_status", 64'(act_tx[3]), 64'h00);

        pl = '{32'h00000010, 32'h00000002};
        run_frame(32'd2, 32'd3);
        wait_done("download_done");
        check("download_byte_count", 64'(act_tx.size()), 64'd12);
        check("download_first", 64'(act_tx[0]), 64'hAA);
        check("download_second_word_last", 64'(act_tx[7]), 64'h04);

        pl = '{32'hDEADBEEF, 32'hCAFEF00D};
        run_frame(32'd2, 32'd7);
        wait_done("unknown_done");
        check("unknown_status", 64'(act_tx[3]), 64'h01);

        pl = '{32'h00000042};
        run_frame(32'd1, 32'd3);
        wait_done("badlen_done");
        check("badlen_status", 64'(act_tx[3]), 64'h03);

        act_tx.delete();
        push_word(32'd2);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("busy_partial_word", 64'(busy), 64'd1);
        t_tx1 = -1;
        wait_done("timeout_done");
        check("timeout_delay_ok", 64'((t_tx1 - t_rx) >= TMO && (t_tx1 - t_rx) <= TMO + 4), 64'd1);
        check("timeout_status", 64'(act_tx[3]), 64'h02);

        pl.delete();
        run_frame(32'd0, 32'd0);
        wait_done("nop_after_timeout_done");
        check("nop_after_timeout_count", 64'(act_tx.size()), 64'd4);
        check("overrun_clear", 64'(overrun), 64'd0);

        run_frame(32'd0, 32'd0);
        repeat (2) @(posedge clk);
        send_byte(8'h5A);
        wait_done("overrun_frame_done");
        check("overrun_set", 64'(overrun), 64'd1);
        check("overrun_status_count", 64'(act_tx.size()), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_cmd_engine.md
Name: serial_cmd_engine

Overview:
- Parametrised successor to the byte-serial command processor. Sits between the UART byte RX/TX pair and a word-addressed memory port.
- Assembles big-endian bytes into WORD_W-bit words and decodes framed commands: NOP, INFO, UPLOAD, DOWNLOAD.
- Ends every command with a status word. Adds inter-byte timeout recovery and drains malformed frames.

Parameters:
- WORD_W, 32, data/command word width in bits; multiple of 8, 16..64; BYTES = WORD_W/8.
- ADDR_W, 16, memory word-address width; must be <= WORD_W.
- TIMEOUT_CYCLES, 100000, idle clocks between RX bytes before an in-progress frame is aborted; >= 2.
- INFO_ID, 32'h4D495053, identifier returned by INFO; zero-extended or truncated to WORD_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_byte valid
- tx_byte  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse, start transmitting tx_byte
- tx_ready  in  1  transmitter idle; drops the cycle after accepting tx_start
- mem_wr  out  1  one-cycle write strobe
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write data
- mem_rdata  in  WORD_W  read data
- mem_rvalid  in  1  mem_rdata valid; arrives >= 1 cycle after mem_rd
- busy  out  1  high whenever state != RD_LEN or a partial word is held
- overrun  out  1  sticky; set when an rx_valid byte is discarded during a transmit state

Behaviour:
- Reset: all outputs 0. State RD_LEN, byte counter 0, timeout counter 0.
- Frame format: LEN word (payload word count), CMD word, then LEN payload words. Each word is BYTES bytes, MSB byte first.
- RX assembly: a word is complete on the rx_valid that delivers its last byte. The state acts on it in the next cycle.
- Commands: NOP=0, INFO=1, UPLOAD=2, DOWNLOAD=3.
- Status codes, zero-extended to WORD_W: 0 OK, 1 unknown command, 2 timeout, 3 bad length.
- States: RD_LEN, RD_CMD, RD_ARG, UP_DATA, DL_READ, DL_WAIT, SEND, DRAIN, STATUS.
- RD_LEN: on word complete, latch LEN and go to RD_CMD.
- RD_CMD, on word complete, by command:
  - NOP, LEN=0: go to STATUS(0).
  - INFO, LEN=0: SEND queues 3 words (INFO_ID, WORD_W, ADDR_W), then STATUS(0).
  - UPLOAD, LEN>=1: go to RD_ARG.
  - DOWNLOAD, LEN=2: go to RD_ARG.
  - Unknown command: DRAIN, then STATUS(1).
  - Length mismatch on a known command: DRAIN, then STATUS(3).
  - DRAIN with LEN=0 skips straight to STATUS.
- RD_ARG:
  - First payload word's low ADDR_W bits become the address.
  - UPLOAD: LEN=1 goes to STATUS(0) with no writes; otherwise go to UP_DATA.
  - DOWNLOAD: second payload word is COUNT. COUNT=0 goes to STATUS(0); otherwise go to DL_READ.
- UP_DATA:
  - Each completed word pulses mem_wr one cycle later with the current mem_addr and mem_wdata, then increments the address.
  - After LEN-1 words, go to STATUS(0).
- Address arithmetic: increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- DL_READ / DL_WAIT:
  - Pulse mem_rd for one cycle, wait for mem_rvalid, capture mem_rdata, SEND it, increment the address.
  - Repeat COUNT times, then STATUS(0).
  - At most one read is outstanding.
- SEND / STATUS serializer:
  - tx_start is asserted only when tx_ready=1 and tx_start was 0 the previous cycle.
  - Bytes go out MSB first, BYTES pulses per word.
  - STATUS returns to RD_LEN after the last byte of the status word is accepted.
- Timeout:
  - Counter clears on every rx_valid.
  - Counts while in RD_CMD, RD_ARG, UP_DATA, DRAIN, or RD_LEN with a partial word.
  - On reaching TIMEOUT_CYCLES: discard the partial word, send STATUS(2), return to RD_LEN.
  - Memory writes already issued stand.
  - The timeout is inactive in DL_READ, DL_WAIT, SEND and STATUS.
- Discarded bytes: rx_valid during DL_READ, DL_WAIT, SEND or STATUS drops the byte and sets overrun.
- Simultaneous events: rx_valid in the same cycle the timeout expires counts as activity, so no timeout.
- Reset mid-operation: an immediate return to reset values. Any byte transfer in progress is abandoned, and no further strobes are issued.

Test Plan:
- Reset, then NOP frame (LEN=0, CMD=0) -> exactly 4 tx bytes 00 00 00 00; no mem strobes; busy low after the last byte.
- INFO frame, LEN=0 -> tx bytes 4D 49 50 53, 00 00 00 20, 00 00 00 10, 00 00 00 00.
- UPLOAD LEN=4, addr 0xFFFE, data 11111111/22222222/33333333 -> mem_wr at FFFE, FFFF, 0000 with those data; status 0.
- DOWNLOAD LEN=2, addr 0x0010, COUNT=2, memory returns AABBCCDD then 01020304 with 3-cycle latency -> tx AA BB CC DD 01 02 03 04 then status 0.
- CMD=7, LEN=2 with 2 junk words -> junk words drained, no strobes, status 00000001. DOWNLOAD with LEN=1 -> status 00000003.
- Send 2 bytes of LEN, then idle for TIMEOUT_CYCLES -> status 00000002; the following valid NOP frame is answered normally with status 0.
